// File: rtl/prbs_pkg.sv
// prbs_pkg: constants and types shared by the PRBS generator and checker.
//   PRBS7_LEN/PRBS7_TAP_A/PRBS7_TAP_B : default polynomial x^7+x^6+1
//   chk_state_e                       : checker synchronisation states
package prbs_pkg;

  localparam int unsigned PRBS7_LEN   = 7;
  localparam int unsigned PRBS7_TAP_A = 7;
  localparam int unsigned PRBS7_TAP_B = 6;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/prbs_err_window.sv
// prbs_err_window: sliding loss-of-lock window for the PRBS checker.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clear both window counters (on entry to LOCKED)
//   valid      : a bit is being checked while LOCKED
//   mis        : that bit mismatched its prediction
//   loss       : combinational; this mismatch is the LOSS_THRESH-th in the window
module prbs_err_window #(
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic valid,
  input  logic mis,
  output logic loss
);

  localparam int unsigned BIT_W = $clog2(WIN_LEN + 1);
  localparam int unsigned ERR_W = $clog2(LOSS_THRESH + 1);

  logic [BIT_W-1:0] wbit_q, wbit_d;
  logic [ERR_W-1:0] werr_q, werr_d;

  // Window counters and threshold compare; loss beats a same-cycle rollover.
  always_comb begin
    wbit_d = wbit_q;
    werr_d = werr_q;
    loss   = valid && mis && (werr_q == ERR_W'(LOSS_THRESH - 1));
    if (clr) begin
      wbit_d = '0;
      werr_d = '0;
    end else if (valid) begin
      if (loss || (wbit_q == BIT_W'(WIN_LEN - 1))) begin
        wbit_d = '0;
        werr_d = '0;
      end else begin
        wbit_d = wbit_q + BIT_W'(1);
        if (mis) werr_d = werr_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbit_q <= '0;
      werr_q <= '0;
    end else begin
      wbit_q <= wbit_d;
      werr_q <= werr_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock detection and
// bit-error counting.
//   clk, reset : clock, asynchronous active-high reset
//   din        : received PRBS bit, sampled when din_valid=1
//   clear_cnt  : synchronous clear of err_cnt and bit_cnt
//   locked     : checker is in LOCKED
//   err        : one-cycle pulse per mismatching bit while LOCKED
//   err_cnt    : saturating mismatch count while LOCKED
//   bit_cnt    : saturating checked-bit count while LOCKED
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_LEN    = PRBS7_LEN,
  parameter int unsigned TAP_A       = PRBS7_TAP_A,
  parameter int unsigned TAP_B       = PRBS7_TAP_B,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FILL_W  = $clog2(LFSR_LEN + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned IDX_A   = TAP_A - 1;
  localparam int unsigned IDX_B   = TAP_B - 1;

  chk_state_e          state_q, state_d;
  logic [LFSR_LEN-1:0] sr_q, sr_d, sr_shift;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                err_q, err_d;
  logic                locked_q;
  logic                mis, sr_zero, win_clr_c, win_valid, loss;

  // The register always loads the received bit, so one line error
  // disturbs exactly the predictions that read it back through the taps.
  assign mis       = din ^ (sr_q[IDX_A] ^ sr_q[IDX_B]);
  assign sr_shift  = {sr_q[LFSR_LEN-2:0], din};
  assign sr_zero   = (sr_shift == '0);
  assign win_valid = din_valid && (state_q == LOCKED);

  prbs_err_window #(
    .WIN_LEN     (WIN_LEN),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .clr   (win_clr_c),
    .valid (win_valid),
    .mis   (mis),
    .loss  (loss)
  );

  // Next-state, shift register and counter logic.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = 1'b0;
    win_clr_c = 1'b0;
    if (din_valid) begin
      sr_d = sr_shift;
      unique case (state_q)
        HUNT: begin
          if (fill_q == FILL_W'(LFSR_LEN - 1)) begin
            state_d = SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        SYNC: begin
          if (mis) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d   = LOCKED;
            match_d   = '0;
            win_clr_c = 1'b1;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
          // A stuck-at-0 line would otherwise predict itself perfectly.
          if (sr_zero) begin
            state_d = HUNT;
            fill_d  = '0;
          end
        end
        LOCKED: begin
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (mis) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (loss || sr_zero) begin
            state_d = HUNT;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end
    if (clear_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios with randomised PRBS seeds and valid
// patterns, checked every cycle against a bit-history reference model.
module tb_prbs_checker;

  localparam int unsigned LEN  = 7;
  localparam int unsigned TA   = 7;
  localparam int unsigned TB   = 6;
  localparam int unsigned LOCK = 16;
  localparam int unsigned WIN  = 64;
  localparam int unsigned THR  = 8;
  localparam int unsigned CW   = 8;
  localparam longint      CMAX = (longint'(1) << CW) - 1;

  localparam int MH = 0;
  localparam int MS = 1;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: received-bit history plus plain integer bookkeeping.
  logic   hist[$];
  int     m_mode, m_fill, m_run, m_wbits, m_werr;
  longint m_err_cnt, m_bit_cnt;
  logic   m_err, m_locked;
  logic [6:0] gen_q;

  prbs_checker #(
    .LFSR_LEN    (LEN),
    .TAP_A       (TA),
    .TAP_B       (TB),
    .LOCK_CNT    (LOCK),
    .WIN_LEN     (WIN),
    .LOSS_THRESH (THR),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit received k valid bits ago (k=1 is the newest); zeros before reset.
  function automatic logic hbit(input int k);
    if (hist.size() >= k) return hist[hist.size() - k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = MH; m_fill = 0; m_run = 0; m_wbits = 0; m_werr = 0;
    m_err_cnt = 0; m_bit_cnt = 0; m_err = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic v, input logic c);
    logic pred, mis, zero;
    m_err = 1'b0;
    if (v) begin
      pred = hbit(int'(TA)) ^ hbit(int'(TB));
      mis  = d ^ pred;
      hist.push_back(d);
      if (hist.size() > 32) hist.delete(0);
      zero = 1'b1;
      for (int k = 1; k <= int'(LEN); k++) if (hbit(k)) zero = 1'b0;
      case (m_mode)
        MH: begin
          m_fill++;
          if (m_fill == int'(LEN)) begin m_mode = MS; m_run = 0; end
        end
        MS: begin
          m_run = mis ? 0 : m_run + 1;
          if (zero) begin m_mode = MH; m_fill = 0; end
          else if (m_run == int'(LOCK)) begin m_mode = ML; m_wbits = 0; m_werr = 0; end
        end
        default: begin
          if (m_bit_cnt < CMAX) m_bit_cnt++;
          m_wbits++;
          if (mis) begin
            m_err = 1'b1;
            if (m_err_cnt < CMAX) m_err_cnt++;
            m_werr++;
          end
          if (m_werr == int'(THR) || zero) begin m_mode = MH; m_fill = 0; end
          else if (m_wbits == int'(WIN)) begin m_wbits = 0; m_werr = 0; end
        end
      endcase
    end
    if (c) begin m_err_cnt = 0; m_bit_cnt = 0; end
    m_locked = (m_mode == ML);
  endtask

  // Fibonacci PRBS7 source: new bit = bit 7 ago ^ bit 6 ago.
  task automatic gen_bit(output logic b);
    b = gen_q[6] ^ gen_q[5];
    gen_q = {gen_q[5:0], b};
  endtask

  task automatic cyc(input logic d, input logic v, input logic c);
    din = d; din_valid = v; clear_cnt = c;
    @(posedge clk);
    model_step(d, v, c);
    #1;
    chk("locked", 64'(locked), 64'(m_locked));
    chk("err", 64'(err), 64'(m_err));
    chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
    chk("bit_cnt", 64'(bit_cnt), 64'(m_bit_cnt));
  endtask

  task automatic clean(input logic flip, input logic c);
    logic b;
    gen_bit(b);
    cyc(b ^ flip, 1'b1, c);
  endtask

  task automatic do_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("rst_bit_cnt", 64'(bit_cnt), 64'(0));
    #9;
    reset = 1'b0;
  endtask

  initial begin
    int lock_at, lost_at, relock, nv, any_lock, false_err;
    logic [31:0] mask;
    logic b;

    // Clean stream from reset.
    #2;
    do_reset();
    gen_q = 7'($urandom_range(1, 127));
    lock_at = -1;
    for (int i = 1; i <= 200; i++) begin
      clean(1'b0, 1'b0);
      if (locked === 1'b1 && lock_at < 0) lock_at = i;
    end
    chk("lock_at_23", 64'(lock_at), 64'(23));
    chk("clean_err_cnt", 64'(err_cnt), 64'(0));
    chk("clean_bit_cnt", 64'(bit_cnt), 64'(177));

    // Single inverted bit: mismatches at +0, +6, +7.
    repeat (20) clean(1'b0, 1'b0);
    mask = '0;
    for (int i = 0; i < 20; i++) begin
      clean(i == 0, 1'b0);
      if (err === 1'b1) mask[i] = 1'b1;
    end
    chk("single_err_offsets", 64'(mask), 64'(32'h0000_00C1));
    chk("single_err_cnt", 64'(err_cnt), 64'(3));
    chk("single_locked", 64'(locked), 64'(1));

    // bit_cnt saturates instead of wrapping.
    repeat (60) clean(1'b0, 1'b0);
    chk("bit_cnt_sat", 64'(bit_cnt), 64'(CMAX));

    // clear_cnt wins over a same-cycle increment.
    clean(1'b0, 1'b1);
    chk("clr_err_cnt", 64'(err_cnt), 64'(0));
    chk("clr_bit_cnt", 64'(bit_cnt), 64'(0));
    clean(1'b1, 1'b1);
    chk("clr_mis_err", 64'(err), 64'(1));
    chk("clr_mis_err_cnt", 64'(err_cnt), 64'(0));
    repeat (10) clean(1'b0, 1'b0);
    chk("post_clr_err_cnt", 64'(err_cnt), 64'(2));
    chk("post_clr_bit_cnt", 64'(bit_cnt), 64'(10));

    // Three errors 10 apart inside one fresh window force loss of lock.
    for (int g = 0; g < 100 && m_wbits != 0; g++) clean(1'b0, 1'b0);
    lost_at = -1;
    for (int i = 0; i < 27; i++) begin
      clean(i == 0 || i == 10 || i == 20, 1'b0);
      if (locked === 1'b0 && lost_at < 0) lost_at = i;
    end
    chk("loss_at_8th_err", 64'(lost_at), 64'(26));
    chk("loss_err_cnt", 64'(err_cnt), 64'(10));
    relock = -1;
    for (int i = 1; i <= 60; i++) begin
      clean(1'b0, 1'b0);
      if (locked === 1'b1 && relock < 0) relock = i;
    end
    chk("relock_after_loss", 64'(relock), 64'(23));

    // Stuck-at-0 line never locks.
    do_reset();
    any_lock = 0;
    repeat (100) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) any_lock = 1;
    end
    chk("zero_never_locks", 64'(any_lock), 64'(0));
    chk("zero_err_cnt", 64'(err_cnt), 64'(0));

    // 50% din_valid: lock counts valid bits, not cycles.
    do_reset();
    gen_q = 7'($urandom_range(1, 127));
    nv = 0; lock_at = -1; false_err = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_bit(b);
        cyc(b, 1'b1, 1'b0);
        nv++;
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      if (err !== 1'b0) false_err = 1;
      if (locked === 1'b1 && lock_at < 0) lock_at = nv;
    end
    chk("gated_lock_valid_bits", 64'(lock_at), 64'(23));
    chk("gated_no_false_err", 64'(false_err), 64'(0));

    // Asynchronous reset while LOCKED, then relock.
    repeat (5) clean(1'b0, 1'b0);
    chk("pre_reset_locked", 64'(locked), 64'(1));
    do_reset();
    relock = -1;
    for (int i = 1; i <= 40; i++) begin
      clean(1'b0, 1'b0);
      if (locked === 1'b1 && relock < 0) relock = i;
    end
    chk("relock_after_reset", 64'(relock), 64'(23));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
